// File: rtl/bt_psd_avg_reader.sv
// bt_psd_avg_reader: consumer of the estimator PSD port. Reads one frame of
// 2^LOGN bins per psd_ready, accumulates 2^LOG_SEG good frames per bin, then
// streams the averaged PSD over a valid/ready port.
// Build macro BT_PSD_AVG_ROUND_EN: round-half-up average with saturation;
// when undefined the average is a truncating shift.
module bt_psd_avg_reader #(
  parameter int W       = 16,
  parameter int LOGN    = 8,
  parameter int LOG_SEG = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psd_ready,
  input  logic             avg_clear,
  output logic             psd_read_en,
  input  logic             psd_valid,
  input  logic [W-1:0]     psd_bin,
  input  logic             psd_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_bin,
  output logic [LOGN-1:0]  out_idx,
  output logic             out_last,
  output logic             busy,
  output logic [LOG_SEG:0] seg_count,
  output logic             err_len,
  output logic             overrun
);
  localparam int ACC_W = W + LOG_SEG;
  localparam int N     = 1 << LOGN;
  localparam int RND   = (1 << LOG_SEG) >> 1;
  localparam logic [LOGN-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_OUT} state_t;

  function automatic logic [W-1:0] f_avg(input logic [ACC_W-1:0] x);
`ifdef BT_PSD_AVG_ROUND_EN
    logic [ACC_W:0] sum;
    logic [ACC_W:0] shr;
    sum = {1'b0, x} + (ACC_W+1)'(RND);
    shr = sum >> LOG_SEG;
    if (|shr[ACC_W:W]) return '1;
    return shr[W-1:0];
`else
    return W'(x >> LOG_SEG);
`endif
  endfunction

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc [N];
  logic [LOGN-1:0]    r_bin_idx;
  logic               r_read_en, r_out_valid, r_out_last, r_busy;
  logic               r_err_len, r_overrun;
  logic [W-1:0]       r_out_bin;
  logic [LOGN-1:0]    r_out_idx;
  logic [LOG_SEG:0]   r_seg_count;

  logic               w_wr, w_good, w_bad, w_seg_done, w_xfer, w_out_end;
  logic [LOG_SEG:0]   w_seg_inc;
  logic [ACC_W-1:0]   w_wdata, w_acc0;
  logic [LOGN-1:0]    w_out_idx_nxt;

  // A frame ends on psd_last or on the final bin slot; good only when both agree.
  assign w_wr          = (r_state == S_READ) && psd_valid && !avg_clear;
  assign w_good        = w_wr && psd_last && (r_bin_idx == LAST_IDX);
  assign w_bad         = w_wr && (psd_last != (r_bin_idx == LAST_IDX));
  assign w_seg_inc     = r_seg_count + 1'b1;
  assign w_seg_done    = w_seg_inc[LOG_SEG];
  assign w_wdata       = (r_seg_count == '0) ? ACC_W'(psd_bin)
                                             : r_acc[r_bin_idx] + ACC_W'(psd_bin);
  assign w_acc0        = (r_bin_idx == '0) ? w_wdata : r_acc[0];
  assign w_xfer        = r_out_valid && out_ready;
  assign w_out_end     = (r_state == S_OUT) && w_xfer && (r_out_idx == LAST_IDX);
  assign w_out_idx_nxt = r_out_idx + 1'b1;

  assign psd_read_en = r_read_en;
  assign out_valid   = r_out_valid;
  assign out_bin     = r_out_bin;
  assign out_idx     = r_out_idx;
  assign out_last    = r_out_last;
  assign busy        = r_busy;
  assign seg_count   = r_seg_count;
  assign err_len     = r_err_len;
  assign overrun     = r_overrun;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; avg_clear overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    if (avg_clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (psd_ready) w_state_nxt = S_READ;
        S_READ: begin
          if (w_good)     w_state_nxt = w_seg_done ? S_OUT : S_IDLE;
          else if (w_bad) w_state_nxt = S_IDLE;
        end
        S_OUT:  if (w_out_end) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Control registers: indices, segment count, handshake and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_bin_idx   <= '0;
      r_seg_count <= '0;
      r_err_len   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_read_en <= (w_state_nxt == S_READ);
      r_busy    <= (w_state_nxt != S_IDLE);
      if (psd_ready && !avg_clear && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (avg_clear) begin
        r_seg_count <= '0;
        r_bin_idx   <= '0;
        r_out_idx   <= '0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (psd_ready) r_bin_idx <= '0;
          S_READ: begin
            if (w_good) begin
              r_seg_count <= w_seg_inc;
              r_bin_idx   <= '0;
              if (w_seg_done) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= '0;
                r_out_last  <= (N == 1);
              end
            end else if (w_bad) begin
              r_err_len   <= 1'b1;
              r_seg_count <= '0;
              r_bin_idx   <= '0;
            end else if (w_wr) begin
              r_bin_idx <= r_bin_idx + 1'b1;
            end
          end
          S_OUT: begin
            if (w_out_end) begin
              r_out_valid <= 1'b0;
              r_seg_count <= '0;
              r_out_idx   <= '0;
              r_out_last  <= 1'b0;
            end else if (w_xfer) begin
              r_out_idx  <= w_out_idx_nxt;
              r_out_last <= (w_out_idx_nxt == LAST_IDX);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Accumulator write: first frame of an average overwrites, later ones add.
  always_ff @(posedge clk) begin
    if (w_wr) r_acc[r_bin_idx] <= w_wdata;
  end

  // Averaged output bin: loaded on entry to streaming and on each transfer.
  always_ff @(posedge clk) begin
    if (rst)
      r_out_bin <= '0;
    else if (w_good && w_seg_done)
      r_out_bin <= f_avg(w_acc0);
    else if ((r_state == S_OUT) && w_xfer && !w_out_end && !avg_clear)
      r_out_bin <= f_avg(r_acc[w_out_idx_nxt]);
  end
endmodule

// File: tb/tb_bt_psd_avg_reader.sv
// Directed-sequence bench for bt_psd_avg_reader with randomized bin values
// and valid/ready gaps, checked against a per-bin running-sum model.
module tb_bt_psd_avg_reader;
  localparam int W       = 16;
  localparam int LOGN    = 8;
  localparam int LOG_SEG = 3;
  localparam int N       = 1 << LOGN;
  localparam int M       = 1 << LOG_SEG;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             psd_ready = 1'b0;
  logic             avg_clear = 1'b0;
  logic             psd_read_en;
  logic             psd_valid = 1'b0;
  logic [W-1:0]     psd_bin = '0;
  logic             psd_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_bin;
  logic [LOGN-1:0]  out_idx;
  logic             out_last;
  logic             busy;
  logic [LOG_SEG:0] seg_count;
  logic             err_len;
  logic             overrun;

  int checks = 0;
  int errors = 0;
  int sum  [N];
  int vals [N];
  int model_seg = 0;

  always #5 clk = ~clk;

  bt_psd_avg_reader #(.W(W), .LOGN(LOGN), .LOG_SEG(LOG_SEG)) dut (
    .clk(clk), .rst(rst), .psd_ready(psd_ready), .avg_clear(avg_clear),
    .psd_read_en(psd_read_en), .psd_valid(psd_valid), .psd_bin(psd_bin),
    .psd_last(psd_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .seg_count(seg_count), .err_len(err_len), .overrun(overrun)
  );

  initial begin
    #5_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_avg(input int k);
    longint s;
    s = sum[k];
`ifdef BT_PSD_AVG_ROUND_EN
    s = (s + M / 2) / M;
    if (s > (1 << W) - 1) s = (1 << W) - 1;
`else
    s = s / M;
`endif
    return int'(s);
  endfunction

  task automatic do_reset();
    rst = 1'b1; psd_ready = 1'b0; avg_clear = 1'b0; psd_valid = 1'b0;
    psd_last = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    model_seg = 0;
  endtask

  // mode 0: constant base, 1: k+base, 2: random. len<N: psd_last early.
  // long_err: N bins without psd_last. ovr_at/clr_at: bin index or -1.
  task automatic frame(input int mode, input int base, input int len,
                       input bit long_err, input int ovr_at, input int clr_at);
    int cnt;
    int v;
    psd_ready = 1'b1;
    step();
    psd_ready = 1'b0;
    check("read_en_rise", psd_read_en, 1);
    check("busy_rise", busy, 1);
    cnt = long_err ? N : len;
    for (int k = 0; k < cnt; k++) begin
      if ($urandom_range(0, 3) == 0) step();
      if (k == cnt / 2) check("read_en_hold", psd_read_en, 1);
      if (k == clr_at) begin
        avg_clear = 1'b1;
        step();
        avg_clear = 1'b0;
        check("clr_read_en", psd_read_en, 0);
        check("clr_seg", seg_count, 0);
        model_seg = 0;
        return;
      end
      v = (mode == 0) ? base : (mode == 1) ? k + base : int'($urandom_range(0, (1 << W) - 1));
      vals[k]   = v;
      psd_valid = 1'b1;
      psd_bin   = W'(v);
      psd_last  = !long_err && (k == cnt - 1);
      psd_ready = (k == ovr_at);
      step();
      psd_valid = 1'b0;
      psd_last  = 1'b0;
      psd_ready = 1'b0;
    end
    check("read_en_drop", psd_read_en, 0);
    if (!long_err && len == N) begin
      for (int k = 0; k < N; k++) sum[k] = (model_seg == 0) ? vals[k] : sum[k] + vals[k];
      model_seg++;
    end else begin
      model_seg = 0;
      check("err_len_set", err_len, 1);
    end
    check("seg_count", seg_count, model_seg);
    if (model_seg == M) begin
      check("out_valid_rise", out_valid, 1);
      check("out_idx_first", out_idx, 0);
      check("out_bin_first", out_bin, exp_avg(0));
    end
  endtask

  task automatic drain(input int stall_idx, input bit rnd_ready, input int ovr_idx);
    int idx;
    int budget;
    int sidx;
    idx = 0; budget = 0; sidx = stall_idx;
    while (idx < N && budget < 4 * N) begin
      budget++;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == sidx) begin
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          check("stall_idx", out_idx, idx);
          check("stall_bin", out_bin, exp_avg(idx));
          step();
        end
        sidx = -1;
        out_ready = 1'b1;
      end
      psd_ready = (idx == ovr_idx);
      if (out_ready) begin
        check("out_valid", out_valid, 1);
        check("out_idx", out_idx, idx);
        check("out_bin", out_bin, exp_avg(idx));
        check("out_last", out_last, (idx == N - 1) ? 1 : 0);
        idx++;
      end
      step();
      psd_ready = 1'b0;
    end
    out_ready = 1'b0;
    check("drain_done", idx, N);
    check("end_out_valid", out_valid, 0);
    check("end_busy", busy, 0);
    check("end_seg", seg_count, 0);
    model_seg = 0;
  endtask

  initial begin
    do_reset();
    check("rst_read_en", psd_read_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bin", out_bin, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_seg", seg_count, 0);
    check("rst_err_len", err_len, 0);
    check("rst_overrun", overrun, 0);

    // Clear and ready together: clear wins, nothing starts, no overrun.
    avg_clear = 1'b1; psd_ready = 1'b1;
    step();
    avg_clear = 1'b0; psd_ready = 1'b0;
    step();
    check("clr_rdy_busy", busy, 0);
    check("clr_rdy_read_en", psd_read_en, 0);
    check("clr_rdy_overrun", overrun, 0);

    // Constant frames.
    for (int s = 0; s < M; s++) frame(0, 100, N, 1'b0, -1, -1);
    drain(-1, 1'b0, -1);

    // Ramp frames with a stall at index 10.
    for (int s = 0; s < M; s++) frame(1, s, N, 1'b0, -1, -1);
    drain(10, 1'b0, -1);

    // Short frame aborts the average.
    frame(0, 50, N, 1'b0, -1, -1);
    frame(0, 50, N, 1'b0, -1, -1);
    frame(0, 50, 101, 1'b0, -1, -1);
    for (int s = 0; s < M; s++) frame(0, 50, N, 1'b0, -1, -1);
    drain(-1, 1'b0, -1);

    // Overrun during READ; random data, random sink backpressure.
    check("ovr_before", overrun, 0);
    frame(2, 0, N, 1'b0, 77, -1);
    check("ovr_read", overrun, 1);
    for (int s = 1; s < M; s++) frame(2, 0, N, 1'b0, -1, -1);
    drain(-1, 1'b1, -1);

    // Reset clears sticky flags; clear mid-frame; overrun during OUT.
    do_reset();
    check("rst2_overrun", overrun, 0);
    check("rst2_err_len", err_len, 0);
    for (int s = 0; s < 4; s++) frame(2, 0, N, 1'b0, -1, -1);
    frame(0, 0, N, 1'b0, -1, 50);
    for (int s = 0; s < M; s++) frame(0, 7, N, 1'b0, -1, -1);
    check("ovr_pre_out", overrun, 0);
    drain(-1, 1'b0, 20);
    check("ovr_out", overrun, 1);
    check("err_len_clean", err_len, 0);

    // Missing psd_last on the final bin.
    frame(0, 9, N, 1'b1, -1, -1);
    check("long_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
